// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_if
// Brief    : Frame request handshake and per-frame configuration bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [3:0]        cfg_bits;
    logic [1:0]        cfg_parity;
    logic              cfg_stop2;
    logic [DIV_W-1:0]  baud_div;

    modport master (
        output s_valid, s_data, cfg_bits, cfg_parity, cfg_stop2, baud_div,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, cfg_bits, cfg_parity, cfg_stop2, baud_div,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : Runtime-configurable UART transmitter with valid/ready intake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    uart_tx_frame_if.slave  s,
    output logic            uart_txd,
    output logic            tx_busy,
    output logic            tx_done
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0]       c_MIN_BITS = 4'd5;
    localparam logic [3:0]       c_MAX_BITS = 4'(DATA_W);
    localparam logic [DIV_W-1:0] c_MIN_DIV  = DIV_W'(2);

    state_t            r_state;
    state_t            w_state_nx;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_div;
    logic [3:0]        r_idx;
    logic [3:0]        r_nbits;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;
    logic              r_txd;

    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_xfer;
    logic              w_txd_nx;
    logic [3:0]        w_bits;
    logic [DIV_W-1:0]  w_div;
    logic              w_par;

    // Clamp the incoming configuration and precompute parity over the live bits only.
    always_comb begin
        w_bits = s.cfg_bits;
        if (s.cfg_bits < c_MIN_BITS) begin
            w_bits = c_MIN_BITS;
        end else if (s.cfg_bits > c_MAX_BITS) begin
            w_bits = c_MAX_BITS;
        end
        w_div = (s.baud_div < c_MIN_DIV) ? c_MIN_DIV : s.baud_div;
        w_par = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < w_bits) begin
                w_par = w_par ^ s.s_data[i];
            end
        end
    end

    assign w_bit_end   = (r_state != S_IDLE) && (r_cnt == r_div - DIV_W'(1));
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_idx == {3'b000, r_stop2});
    assign w_xfer      = s.s_valid && ((r_state == S_IDLE) || w_last_stop);

    assign s.s_ready = (r_state == S_IDLE) || w_last_stop;
    assign uart_txd  = r_txd;
    assign tx_busy   = (r_state != S_IDLE);
    assign tx_done   = w_last_stop;

    // The line is registered, so each branch loads the level of the state being entered.
    always_comb begin
        w_state_nx = r_state;
        w_txd_nx   = r_txd;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nx = S_START;
                    w_txd_nx   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_txd_nx   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == r_nbits - 4'd1) begin
                        w_state_nx = r_par_en ? S_PARITY : S_STOP;
                        w_txd_nx   = r_par_en ? r_par_bit : 1'b1;
                    end else begin
                        w_txd_nx = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = S_STOP;
                    w_txd_nx   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_last_stop) begin
                    w_state_nx = w_xfer ? S_START : S_IDLE;
                    w_txd_nx   = !w_xfer;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_txd_nx   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txd     <= 1'b1;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_div     <= '0;
            r_nbits   <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            r_txd <= w_txd_nx;

            if (w_xfer || w_bit_end) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + DIV_W'(1);
            end

            // r_idx counts data bits in DATA and stop bits in STOP.
            if (w_state_nx != r_state) begin
                r_idx <= '0;
            end else if (w_bit_end) begin
                r_idx <= r_idx + 4'd1;
            end

            if (w_xfer) begin
                r_shift   <= s.s_data;
                r_nbits   <= w_bits;
                r_div     <= w_div;
                r_stop2   <= s.cfg_stop2;
                r_par_en  <= (s.cfg_parity != 2'b00);
                r_par_bit <= (s.cfg_parity == 2'b01) ? w_par :
                             (s.cfg_parity == 2'b10) ? !w_par : 1'b0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift <= r_shift >> 1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Self-checking bench for uart_tx_frame with a cycle-level frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;
    logic clk;
    logic rst_n;
    logic uart_txd;
    logic tx_busy;
    logic tx_done;

    uart_tx_frame_if #(.DATA_W(8), .DIV_W(16)) bus ();

    uart_tx_frame #(.DATA_W(8), .DIV_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (bus),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    logic cap [0:299];

    typedef struct packed {
        logic txd;
        logic done;
    } ev_t;
    ev_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expand the request currently on the bus into one expected line level per clock.
    task automatic model_push();
        int   n, d;
        logic pb;
        logic [7:0] dat;
        logic bl[$];
        dat = bus.s_data;
        n = int'(bus.cfg_bits);
        if (n < 5) n = 5;
        if (n > 8) n = 8;
        d = int'(bus.baud_div);
        if (d < 2) d = 2;
        pb = 1'b0;
        bl.push_back(1'b0);
        for (int k = 0; k < n; k++) begin
            bl.push_back(dat[k]);
            pb = pb ^ dat[k];
        end
        case (bus.cfg_parity)
            2'b01:   bl.push_back(pb);
            2'b10:   bl.push_back(~pb);
            2'b11:   bl.push_back(1'b0);
            default: ;
        endcase
        bl.push_back(1'b1);
        if (bus.cfg_stop2) bl.push_back(1'b1);
        for (int b = 0; b < bl.size(); b++) begin
            for (int c = 0; c < d; c++) begin
                q.push_back('{txd: bl[b], done: (b == bl.size() - 1) && (c == d - 1)});
            end
        end
    endtask

    always @(negedge clk) begin
        logic e_txd, e_done, e_busy, e_ready;
        if (!rst_n) begin
            q.delete();
        end else begin
            e_busy  = (q.size() != 0);
            e_txd   = e_busy ? q[0].txd : 1'b1;
            e_done  = e_busy ? q[0].done : 1'b0;
            e_ready = !e_busy || e_done;
            chk("model_txd",   uart_txd,    e_txd);
            chk("model_busy",  tx_busy,     e_busy);
            chk("model_done",  tx_done,     e_done);
            chk("model_ready", bus.s_ready, e_ready);
            if (e_busy) void'(q.pop_front());
            if (bus.s_valid && e_ready) model_push();
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input logic [7:0] d, input int bits, input int par, input int st2,
                        input int div, input bit hold);
        bit hs;
        bus.s_data     = d;
        bus.cfg_bits   = 4'(bits);
        bus.cfg_parity = 2'(par);
        bus.cfg_stop2  = 1'(st2);
        bus.baud_div   = 16'(div);
        bus.s_valid    = 1'b1;
        hs = 1'b0;
        for (int k = 0; k < 400 && !hs; k++) begin
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
        end
        chk("handshake", hs, 1'b1);
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) bus.s_valid = 1'b0;
    endtask

    task automatic capture(output int idx);
        idx = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cap[i] = uart_txd;
            if (tx_done) begin
                idx = i;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         idx;
        int         ta;
        logic [9:0] exp55;
        logic [2:0] par_exp;
        bit         h;

        rst_n          = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.cfg_bits   = 4'd8;
        bus.cfg_parity = 2'd0;
        bus.cfg_stop2  = 1'b0;
        bus.baud_div   = 16'd4;
        #12;
        chk("rst_txd",   uart_txd,    1'b1);
        chk("rst_busy",  tx_busy,     1'b0);
        chk("rst_done",  tx_done,     1'b0);
        chk("rst_ready", bus.s_ready, 1'b1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8N1, div 4, 0x55
        exp55 = 10'b10_1010_1010;
        send(8'h55, 8, 0, 0, 4, 1'b0);
        capture(idx);
        chk("8n1_done_cycle", idx, 39);
        for (int k = 0; k < 10; k++) chk("8n1_bit", cap[4 * k + 2], exp55[k]);

        // Parity modes on 7 bits of 0x83 with two stop bits
        par_exp = 3'b010;
        for (int p = 1; p <= 3; p++) begin
            send(8'h83, 7, p, 1, 3, 1'b0);
            capture(idx);
            chk("par_done_cycle", idx, 32);
            chk("par_bit", cap[25], par_exp[p - 1]);
        end

        // Back-to-back with s_valid held
        send(8'hA5, 8, 0, 0, 2, 1'b1);
        ta = t0;
        send(8'h3C, 8, 0, 0, 2, 1'b0);
        chk("b2b_gap", t0 - ta, 20);
        capture(idx);
        chk("b2b_done_cycle", idx, 19);

        // Clamping and mid-frame configuration change
        send(8'h15, 2, 0, 0, 0, 1'b0);
        bus.baud_div = 16'd10;
        bus.cfg_bits = 4'd8;
        capture(idx);
        chk("clamp_done_cycle", idx, 13);
        chk("clamp_bit0", cap[2], 1'b1);

        // Stall: request raised during an active frame
        send(8'h11, 8, 2, 0, 3, 1'b0);
        ta = t0;
        send(8'h22, 6, 1, 1, 3, 1'b0);
        chk("stall_gap", t0 - ta, 33);
        capture(idx);
        chk("stall_done_cycle", idx, 29);

        // Asynchronous reset during data bit 3
        send(8'h00, 8, 0, 0, 4, 1'b0);
        repeat (17) @(negedge clk);
        chk("pre_rst_txd", uart_txd, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_txd",   uart_txd,    1'b1);
        chk("arst_busy",  tx_busy,     1'b0);
        chk("arst_done",  tx_done,     1'b0);
        chk("arst_ready", bus.s_ready, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'hF0, 8, 0, 0, 4, 1'b0);
        capture(idx);
        chk("post_rst_done_cycle", idx, 39);

        // Randomized frames, gaps and held requests
        h = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if (!h) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            h = (it != 39) && ($urandom_range(0, 2) == 0);
            send(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 5)), h);
            if (!h) begin
                bus.s_data     = 8'($urandom);
                bus.cfg_bits   = 4'($urandom);
                bus.cfg_parity = 2'($urandom);
                bus.cfg_stop2  = 1'($urandom);
                bus.baud_div   = 16'($urandom_range(0, 9));
            end
        end
        idx = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!tx_busy) begin
                idx = 1;
                break;
            end
        end
        chk("final_idle", idx, 1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the FPGA UART IP, successor to the fixed 8N1 transmitter. It adds a valid/ready input handshake and a runtime baud divisor. Data length (5..DATA_W), parity (none/even/odd/space) and 1 or 2 stop bits are also set at run time. Back-to-back frames go out with no idle gap. It sits between the MCU-bus register block and the `uart_txd` pin.

## Interface
Parameters
- `DATA_W`, 8: width of `s_data`; maximum data bits per frame; legal 5..9.
- `DIV_W`, 16: width of `baud_div`.

Ports
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  frame request.
- `s_ready`  out  1  block can accept a frame this cycle.
- `s_data`  in  DATA_W  payload, transmitted LSB first.
- `cfg_bits`  in  4  data bits per frame, valid 5..DATA_W.
- `cfg_parity`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 space (constant 0).
- `cfg_stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `baud_div`  in  DIV_W  clock cycles per bit.
- `uart_txd`  out  1  serial line, idle high; registered output.
- `tx_busy`  out  1  a frame is in progress.
- `tx_done`  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- A transfer occurs when `s_valid && s_ready` at a rising edge.
- The following are latched at the transfer edge and held for the whole frame: `s_data`, `cfg_*` and `baud_div`. Input changes mid-frame have no effect on the current frame.
- Latched values are clamped as follows:
  - `cfg_bits` < 5 becomes 5; `cfg_bits` > DATA_W becomes DATA_W.
  - `baud_div` < 2 becomes 2.
- States:
  - IDLE: `uart_txd`=1, `s_ready`=1. A transfer moves to START.
  - START: line 0 for div cycles, then DATA.
  - DATA: bits [0..N-1], div cycles each. Then PARITY if parity is enabled, otherwise STOP.
  - PARITY: one bit for div cycles, then STOP.
    - Even mode: XOR of the N transmitted bits.
    - Odd mode: inverse of that XOR.
    - Space mode: 0.
    - Bits above N-1 are excluded from the calculation.
  - STOP: line 1 for div×S cycles (S = 1 or 2), then IDLE. If a transfer occurs on the final stop cycle, go directly to START instead.
- Frame length is L = 1 + N + P + S bits, where P = 0 for parity none and 1 otherwise. Frame duration is div×L cycles.
- Bit timer: a DIV_W counter cleared at every bit boundary. The bit ends when the counter = div−1.
- `s_ready` = (state==IDLE) OR `tx_done`. `s_ready` is combinational from registered state.
- `tx_busy` = 1 in every state except IDLE.

## Timing
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `s_ready`=1. State = IDLE, counters = 0, latched data = 0.
- Reset applied mid-frame: the frame is abandoned and `uart_txd` returns to 1 immediately (asynchronous). There is no stop-bit completion.
- Latency, taking the transfer edge as T0:
  - `uart_txd` falls after edge T0 (1-cycle latency).
  - The start bit occupies edges T0..T0+div.
  - Data bit k starts at edge T0+div×(1+k).
- `tx_done` is high for exactly the cycle preceding edge T0+div×L.
- Back-to-back: a transfer on that edge starts the next start bit at T0+div×L. There is no extra idle cycle, and `tx_busy` stays 1 throughout.
- A transfer arriving while `s_valid` is high but `s_ready` is low is held off. The bench must hold `s_valid`/`s_data` stable until the handshake.
- `s_valid` asserted in IDLE on the same edge as reset release is ignored. The first transfer can occur one edge after reset deasserts.

## Test plan
- Basic 8N1 frame: div=4, bits=8, parity=00, stop2=0, data=0x55.
  - `uart_txd` after T0 is 0,1,0,1,0,1,0,1,0,1, 4 cycles each.
  - `tx_done` pulses once, in cycle 39. `tx_busy` is high for 40 cycles.
- Parity and short data: div=3, bits=7, data=0x83 (bit 7 ignored).
  - Parity 01: the parity bit is 0.
  - Parity 10: the parity bit is 1.
  - Parity 11: the parity bit is 0.
  - With stop2=1, total frame is 3×11=33 cycles.
- Back-to-back: `s_valid` held high with 0xA5 then 0x3C, 8N1, div=2.
  - The second start bit begins on the edge right after `tx_done`.
  - The line shows no idle-high gap beyond the stop bit, and the total is 40 cycles.
- Clamping: baud_div=0 and cfg_bits=2.
  - Behaviour matches baud_div=2 with 5 data bits; frame 5N1 is 14 cycles.
  - Changing `baud_div` to 10 mid-frame does not alter bit widths until the next frame.
- Reset mid-frame: assert `rst_n`=0 during data bit 3.
  - `uart_txd` goes to 1, `tx_busy` and `tx_done` go to 0, and `s_ready` goes to 1, all with no clock.
  - After release, a new frame 0xF0 transmits correctly.
- Stall: `s_valid` asserted during an active frame with `s_ready`=0.
  - No transfer occurs until `tx_done`.
  - The held data is sent next, with no loss or duplication.
